posit_encode_accum_es3: RTL

POSIT_ENCODE_ACCUM_ES3 -- requirements
Module: posit_encode_accum_es3

---
 rtl/posit_encode_accum_es3.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/posit_encode_accum_es3.sv
// posit_encode_accum_es3
//   Three-stage encoder from an accumulator-style (sign, zero, inf, scale,
//   fraction) word to an NBITS-wide posit with ES exponent bits.
//     S1: split scale into regime run length and exponent, detect clamping
//     S2: pack regime/exponent/fraction into the magnitude field and round
//     S3: apply sign (two's complement) and special values, output register
//   The whole pipeline advances together whenever the output register is
//   empty or being drained, so a stall freezes every stage in place.
//
//   Optional feature macro: POSIT_ENCODE_RNE_EN
//     defined   -> round-to-nearest-even (guard bit + sticky OR of the rest)
//     undefined -> truncate discarded bits toward zero (minpos floor kept)
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   in_valid     input word valid
//   in_ready     block accepts an input word this cycle
//   in_sign      input sign
//   in_zero      input is zero
//   in_inf       input is infinity / NaR (wins over in_zero)
//   in_scale     signed scale, k*2^ES + e
//   in_fraction  fraction bits below the hidden one, MSB weight 2^-1
//   out_valid    out_posit/out_sat hold a result
//   out_ready    downstream accepts the result
//   out_posit    encoded posit
//   out_sat      magnitude was clamped to maxpos/minpos
module posit_encode_accum_es3 #(
    parameter int NBITS  = 32,
    parameter int ES     = 3,
    parameter int FRAC_W = 28
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic              in_zero,
    input  logic              in_inf,
    input  logic [8:0]        in_scale,
    input  logic [FRAC_W-1:0] in_fraction,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NBITS-1:0]  out_posit,
    output logic              out_sat
);

    localparam int MAG_W   = NBITS - 1;
    localparam int TAIL_W  = 1 + ES + FRAC_W;      // regime terminator + exponent + fraction
    localparam int SHIFT_W = NBITS + TAIL_W;       // room for the longest run plus the tail
    localparam int RUN_W   = $clog2(NBITS) + 1;
    localparam int SAT_LIM = (NBITS - 2) << ES;    // largest |scale| that still fits
`ifdef POSIT_ENCODE_RNE_EN
    localparam int KEEP_W  = SHIFT_W;              // keep discarded bits for guard/sticky
`else
    localparam int KEEP_W  = MAG_W;                // truncation only needs the kept field
`endif
    localparam logic [MAG_W-1:0] MAXPOS = '1;
    localparam logic [MAG_W-1:0] MINPOS = MAG_W'(1);

    // One enable for the whole pipe: move when the output slot is free or draining.
    logic advance;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = reset | advance;

    // ---------------- S1: regime / exponent split, clamp detect ----------------
    int               scale_i;
    int               k_i;
    logic [RUN_W-1:0] run_c;

    // NOTE: every variable in a combinational block gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        scale_i = int'($signed(in_scale));
        k_i     = scale_i >>> ES;
        // k>=0: k+1 ones then a zero; k<0: -k zeros then a one.
        run_c   = (k_i < 0) ? RUN_W'(-k_i) : RUN_W'(k_i + 1);
    end

    logic              s1_valid, s1_sign, s1_zero, s1_inf, s1_sat_hi, s1_sat_lo, s1_neg;
    logic [RUN_W-1:0]  s1_run;
    logic [ES-1:0]     s1_exp;
    logic [FRAC_W-1:0] s1_frac;

    // NOTE: registers use non-blocking assignments so every stage samples the
    // previous stage's old value on the same edge.
    always_ff @(posedge clk) begin
        if (reset)        s1_valid <= 1'b0;
        else if (advance) s1_valid <= in_valid;
    end

    // NOTE: pipeline data registers are not reset; only the valid bits need a
    // known state, and data is ignored while its valid bit is low.
    always_ff @(posedge clk) begin
        if (advance) begin
            s1_sign   <= in_sign;
            s1_zero   <= in_zero;
            s1_inf    <= in_inf;
            s1_sat_hi <= scale_i > SAT_LIM;
            s1_sat_lo <= scale_i < -SAT_LIM;
            s1_neg    <= k_i < 0;
            s1_run    <= run_c;
            s1_exp    <= in_scale[ES-1:0];
            s1_frac   <= in_fraction;
        end
    end

    // ---------------- S2: pack and round ----------------
    logic [KEEP_W-1:0] base, fill, shifted;
    logic [MAG_W-1:0]  window, mag_c;

    always_comb begin
        // Tail starts with the regime terminator; shifting it right by the run
        // length leaves room for the run, which is ones for k>=0 (fill) and
        // zeros for k<0.
        base    = KEEP_W'({s1_neg, s1_exp, s1_frac, {NBITS{1'b0}}} >> (SHIFT_W - KEEP_W));
        fill    = s1_neg ? '0 : ~({KEEP_W{1'b1}} >> s1_run);
        shifted = (base >> s1_run) | fill;
        window  = shifted[KEEP_W-1 -: MAG_W];
        mag_c   = window;
`ifdef POSIT_ENCODE_RNE_EN
        // Guard is the first discarded bit; the increment may carry into the
        // regime, which is a valid posit, but never past maxpos.
        if (shifted[KEEP_W-1-MAG_W] && ((|shifted[KEEP_W-2-MAG_W:0]) || window[0])
            && (window != MAXPOS))
            mag_c = window + MAG_W'(1);
`endif
        if (mag_c == '0)    mag_c = MINPOS;
        if (s1_sat_hi)      mag_c = MAXPOS;
        else if (s1_sat_lo) mag_c = MINPOS;
    end

    logic             s2_valid, s2_sign, s2_zero, s2_inf, s2_sat;
    logic [MAG_W-1:0] s2_mag;

    always_ff @(posedge clk) begin
        if (reset)        s2_valid <= 1'b0;
        else if (advance) s2_valid <= s1_valid;
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            s2_sign <= s1_sign;
            s2_zero <= s1_zero;
            s2_inf  <= s1_inf;
            s2_sat  <= s1_sat_hi | s1_sat_lo;
            s2_mag  <= mag_c;
        end
    end

    // ---------------- S3: sign negate, specials, output register ----------------
    logic [NBITS-1:0] posit_c;
    logic             sat_c;

    always_comb begin
        posit_c = {1'b0, s2_mag};
        if (s2_sign) posit_c = -posit_c;
        if (s2_zero) posit_c = '0;
        if (s2_inf)  posit_c = {1'b1, {MAG_W{1'b0}}};
        sat_c = s2_sat & ~s2_zero & ~s2_inf;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_posit <= '0;
            out_sat   <= 1'b0;
        end else if (advance) begin
            out_valid <= s2_valid;
            // Bubbles leave the last result in place rather than loading junk.
            if (s2_valid) begin
                out_posit <= posit_c;
                out_sat   <= sat_c;
            end
        end
    end

endmodule
